branch_flow_ctrl: RTL and testbench
===================================

# branch_flow_ctrl

Sequencing controller for conditional branches in the five-stage pipeline. Holds the architectural N/Z/V flag register, interlocks a branch in ID against a flag write in EX, and on a taken branch drives the PC redirect and the IF/ID and ID/EX flushes. The combinational branch-condition evaluator sits alongside: it reads this block's flag outputs and returns `br_taken`.

## Interface
- `ADDR_W`, 16, width of PC and branch target.
- `FLUSH_CYCLES`, 2, total cycles `flush_ifid` is asserted per taken branch; legal range 1..7.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `stall_in` input 1: global pipeline freeze, e.g. memory wait.
- `id_is_br` input 1: ID holds a valid branch (opcode 4'b1100).
- `br_taken` input 1: evaluator result from the current `flag_*` outputs and the ID condition code.
- `br_target` input ADDR_W: computed target of the ID branch.
- `ex_flag_wr` input 1: the EX instruction updates flags.
- `alu_n`, `alu_z`, `alu_v` input 1 each: new flag values from the EX ALU.
- `flag_n`, `flag_z`, `flag_v` output 1 each: registered flag values.
- `flag_stall` output 1: hold PC, IF/ID and ID; insert a bubble into EX.
- `pc_redirect` output 1: load the PC from `redirect_pc`.
- `redirect_pc` output ADDR_W: captured branch target.
- `flush_ifid`, `flush_idex` output 1 each: squash the stage register.

## Operation
- Flag register:
  - Loads `alu_*` on a clock edge when `ex_flag_wr && !stall_in`.
  - Otherwise it holds.
- States: IDLE, INTERLOCK, REDIRECT, FLUSH. There is a 3-bit flush counter `cnt`.
- IDLE:
  - `id_is_br && ex_flag_wr` asserts `flag_stall` combinationally and moves to INTERLOCK.
  - Else `id_is_br && br_taken` captures `br_target` into `redirect_pc` and moves to REDIRECT.
  - Else stays in IDLE.
- INTERLOCK:
  - `flag_stall` is 0.
  - The flags now reflect the producing instruction, and the branch is re-evaluated.
  - If `br_taken`, capture the target and go to REDIRECT; else go to IDLE.
- REDIRECT, one cycle:
  - Asserts `pc_redirect`, `flush_ifid` and `flush_idex`.
  - Loads `cnt` = FLUSH_CYCLES-1.
  - Goes to IDLE if FLUSH_CYCLES==1, else to FLUSH.
- FLUSH:
  - Asserts `flush_ifid` only and decrements `cnt`.
  - Goes to IDLE when `cnt`==1 at the edge.
- `id_is_br` is ignored in REDIRECT and FLUSH, because that instruction is being squashed.
- `stall_in` high: state, `cnt`, flags and `redirect_pc` hold. The Moore outputs stay asserted. `flag_stall` is still driven in IDLE.
- An EX flag write and a not-taken branch in INTERLOCK cost exactly one stall cycle and nothing else.
- All outputs are Moore outputs except `flag_stall`.

## Timing
- Reset values:
  - State is IDLE, and `cnt` is 0.
  - `flag_n`, `flag_z` and `flag_v` are 0, and `redirect_pc` is 0.
  - `pc_redirect`, `flush_ifid`, `flush_idex` and `flag_stall` are 0.
- Reset applies immediately and asynchronously, including mid-REDIRECT or mid-FLUSH. Any pending redirect is lost.
- Taken branch with no interlock:
  - Branch in ID at cycle T.
  - `pc_redirect`, `flush_ifid` and `flush_idex` are high in T+1.
  - `flush_ifid` alone is high in T+2 .. T+FLUSH_CYCLES.
- Interlocked branch:
  - `flag_stall` is high in T.
  - Evaluation happens in T+1.
  - If taken, the redirect is in T+2.
- `redirect_pc` is stable from the REDIRECT cycle until the next capture.

## Configuration
- `BR_FLOW_STATS_EN` defined:
  - Adds outputs `taken_cnt[15:0]` and `stall_cnt[15:0]`. Both reset to 0 and saturate at 16'hFFFF.
  - `taken_cnt` increments on each entry to REDIRECT.
  - `stall_cnt` increments on each IDLE→INTERLOCK transition.
  - Neither counter increments while `stall_in` is high.
- `BR_FLOW_STATS_EN` undefined: these ports and their logic are absent, and behaviour is otherwise identical.

## Test plan
- Reset: assert `rst_n`=0 mid-FLUSH, with flags previously written as 1/1/1. Required: all outputs 0 in the same cycle, and IDLE after release.
- Taken branch, FLUSH_CYCLES=2, `br_target`=16'h0040, no flag write:
  - `pc_redirect` and both flushes for 1 cycle with `redirect_pc`=16'h0040.
  - Then `flush_ifid` alone for 1 cycle, then idle.
- Interlock:
  - Stimulus: `ex_flag_wr`=1 with `alu_z`=1, and a branch-if-equal in ID.
  - `flag_stall`=1 for exactly 1 cycle, and `flag_z`=1 after it.
  - With `br_taken`=1, redirect occurs 2 cycles after the branch entered ID.
- Not taken after interlock: `br_taken`=0 in INTERLOCK. Required: 1 stall cycle, no redirect, no flush.
- `stall_in`=1 for 3 cycles during REDIRECT: outputs held for 4 cycles total, `cnt` unchanged, and the flush sequence resumes after release.
- With `BR_FLOW_STATS_EN`: 70000 taken branches leave `taken_cnt`=16'hFFFF. One interlock leaves `stall_cnt`=1.

Source files
------------

// File: rtl/branch_flow_ctrl.sv
// branch_flow_ctrl: conditional-branch sequencing for the five-stage pipeline.
// Owns the N/Z/V flag register, interlocks an ID branch against an EX flag
// write, and drives the PC redirect plus IF/ID and ID/EX flushes on a taken
// branch.
// Optional build macro BR_FLOW_STATS_EN adds saturating taken/stall counters.
module branch_flow_ctrl #(
  parameter int ADDR_W       = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_in,
  input  logic              id_is_br,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              ex_flag_wr,
  input  logic              alu_n,
  input  logic              alu_z,
  input  logic              alu_v,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_v,
  output logic              flag_stall,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush_ifid,
  output logic              flush_idex
`ifdef BR_FLOW_STATS_EN
  ,
  output logic [15:0]       taken_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INTERLOCK = 2'd1,
    REDIRECT  = 2'd2,
    FLUSH     = 2'd3
  } state_t;

  // REDIRECT accounts for the first flush_ifid cycle, so the counter holds
  // the number of FLUSH cycles still to come.
  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       capture;

  // Next-state, flush counter and the combinational interlock request
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    capture    = 1'b0;
    flag_stall = 1'b0;
    unique case (state)
      IDLE: begin
        // A flag write in EX takes priority: the branch must see its result.
        if (id_is_br && ex_flag_wr) begin
          flag_stall = 1'b1;
          state_nxt  = INTERLOCK;
        end else if (id_is_br && br_taken) begin
          capture   = 1'b1;
          state_nxt = REDIRECT;
        end
      end
      INTERLOCK: begin
        // Flags now hold the producer's result; br_taken is re-evaluated.
        if (br_taken) begin
          capture   = 1'b1;
          state_nxt = REDIRECT;
        end else begin
          state_nxt = IDLE;
        end
      end
      REDIRECT: begin
        cnt_nxt   = CNT_INIT;
        state_nxt = (FLUSH_CYCLES == 1) ? IDLE : FLUSH;
      end
      FLUSH: begin
        // id_is_br is ignored here: that instruction is being squashed.
        cnt_nxt = cnt - 3'd1;
        if (cnt == 3'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter and captured target; everything freezes under stall_in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 3'd0;
      redirect_pc <= '0;
    end else if (!stall_in) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (capture) redirect_pc <= br_target;
    end
  end

  // Architectural flag register, written by the EX ALU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_v <= 1'b0;
    end else if (ex_flag_wr && !stall_in) begin
      flag_n <= alu_n;
      flag_z <= alu_z;
      flag_v <= alu_v;
    end
  end

  // Moore outputs decoded from the state register
  always_comb begin
    pc_redirect = (state == REDIRECT);
    flush_idex  = (state == REDIRECT);
    flush_ifid  = (state == REDIRECT) || (state == FLUSH);
  end

`ifdef BR_FLOW_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic enter_interlock;
  logic enter_redirect;

  // Transition strobes, qualified so a frozen pipeline counts nothing
  always_comb begin
    enter_interlock = !stall_in && (state == IDLE) && (state_nxt == INTERLOCK);
    enter_redirect  = !stall_in && capture;
  end

  // Saturating event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt <= 16'd0;
      stall_cnt <= 16'd0;
    end else begin
      if (enter_redirect)  taken_cnt <= sat_inc(taken_cnt);
      if (enter_interlock) stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_branch_flow_ctrl.sv
// Scoreboard bench for branch_flow_ctrl: stimulus pushes the hand-computed
// per-cycle output vector, a negedge monitor pops and compares.
module tb_branch_flow_ctrl;
  localparam int ADDR_W = 16;
  localparam int VW     = ADDR_W + 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              stall_in, id_is_br, br_taken, ex_flag_wr;
  logic              alu_n, alu_z, alu_v;
  logic [ADDR_W-1:0] br_target;
  logic              flag_n, flag_z, flag_v, flag_stall, pc_redirect;
  logic              flush_ifid, flush_idex;
  logic [ADDR_W-1:0] redirect_pc;
`ifdef BR_FLOW_STATS_EN
  logic [15:0]       taken_cnt, stall_cnt;
`endif

  branch_flow_ctrl #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .stall_in(stall_in), .id_is_br(id_is_br),
    .br_taken(br_taken), .br_target(br_target), .ex_flag_wr(ex_flag_wr),
    .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
    .flag_n(flag_n), .flag_z(flag_z), .flag_v(flag_v),
    .flag_stall(flag_stall), .pc_redirect(pc_redirect),
    .redirect_pc(redirect_pc), .flush_ifid(flush_ifid), .flush_idex(flush_idex)
`ifdef BR_FLOW_STATS_EN
    , .taken_cnt(taken_cnt), .stall_cnt(stall_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  logic [VW-1:0] exp_q[$];
  string         tag_q[$];
  logic [VW-1:0] m_exp;
  string         m_tag;
  logic [VW-1:0] got;

  assign got = {flag_stall, pc_redirect, flush_ifid, flush_idex,
                flag_n, flag_z, flag_v, redirect_pc};

  // {flag_stall, pc_redirect, flush_ifid, flush_idex, n, z, v, redirect_pc}
  function automatic logic [VW-1:0] ev(input logic fs, pr, ff, fi, n, z, v,
                                       input logic [ADDR_W-1:0] rpc);
    return {fs, pr, ff, fi, n, z, v, rpc};
  endfunction

  // Monitor: compare the DUT outputs against the queued expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_exp = exp_q.pop_front();
      m_tag = tag_q.pop_front();
      checks++;
      if (got !== m_exp) begin
        failures++;
        $display("FAIL %s got={fs,pr,ff,fi,n,z,v,pc}=%h required=%h", m_tag, got, m_exp);
      end
    end
  end

  task automatic step(input logic br, tk, input logic [ADDR_W-1:0] tgt,
                      input logic fw, an, az, av, st,
                      input logic [VW-1:0] e, input string tag);
    id_is_br   = br;
    br_taken   = tk;
    br_target  = tgt;
    ex_flag_wr = fw;
    alu_n      = an;
    alu_z      = az;
    alu_v      = av;
    stall_in   = st;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step(input logic [VW-1:0] e, input string tag);
    step(0, 0, '0, 0, 0, 0, 0, 0, e, tag);
  endtask

`ifdef BR_FLOW_STATS_EN
  task automatic check16(input logic [15:0] g, input logic [15:0] r, input string tag);
    checks++;
    if (g !== r) begin
      failures++;
      $display("FAIL %s got=%h required=%h", tag, g, r);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    stall_in = 0; id_is_br = 0; br_taken = 0; ex_flag_wr = 0;
    alu_n = 0; alu_z = 0; alu_v = 0; br_target = '0;
    @(posedge clk);
    #1;

    // Reset held: flag write attempt must be ignored
    step(0, 0, '0, 1, 1, 1, 1, 0, ev(0,0,0,0,0,0,0,16'h0000), "reset_state");
    rst_n = 1'b1;

    // Taken branch, no flag write; ID branch ignored during redirect/flush
    step(1, 1, 16'h0040, 0, 0, 0, 0, 0, ev(0,0,0,0,0,0,0,16'h0000), "A_issue");
    step(1, 1, 16'h0099, 0, 0, 0, 0, 0, ev(0,1,1,1,0,0,0,16'h0040), "A_redirect");
    step(1, 1, 16'h0099, 0, 0, 0, 0, 0, ev(0,0,1,0,0,0,0,16'h0040), "A_flush");
    idle_step(ev(0,0,0,0,0,0,0,16'h0040), "A_idle");

    // Interlock then taken (branch-if-equal after Z is produced)
    step(1, 0, 16'h0123, 1, 0, 1, 0, 0, ev(1,0,0,0,0,0,0,16'h0040), "B_stall");
    step(1, 1, 16'h0123, 0, 0, 0, 0, 0, ev(0,0,0,0,0,1,0,16'h0040), "B_reeval");
    idle_step(ev(0,1,1,1,0,1,0,16'h0123), "B_redirect");
    idle_step(ev(0,0,1,0,0,1,0,16'h0123), "B_flush");
    idle_step(ev(0,0,0,0,0,1,0,16'h0123), "B_idle");

    // Interlock wins over br_taken in IDLE; not taken afterwards
    step(1, 1, 16'h0555, 1, 1, 0, 0, 0, ev(1,0,0,0,0,1,0,16'h0123), "C_stall");
    step(1, 0, 16'h0555, 0, 0, 0, 0, 0, ev(0,0,0,0,1,0,0,16'h0123), "C_nottaken");
    idle_step(ev(0,0,0,0,1,0,0,16'h0123), "C_idle0");
    idle_step(ev(0,0,0,0,1,0,0,16'h0123), "C_idle1");

    // stall_in for 3 cycles in REDIRECT; flag write blocked while frozen
    step(1, 1, 16'h0BEE, 0, 0, 0, 0, 0, ev(0,0,0,0,1,0,0,16'h0123), "D_issue");
    step(0, 0, '0, 1, 1, 1, 1, 1, ev(0,1,1,1,1,0,0,16'h0BEE), "D_hold0");
    step(0, 0, '0, 1, 1, 1, 1, 1, ev(0,1,1,1,1,0,0,16'h0BEE), "D_hold1");
    step(0, 0, '0, 1, 1, 1, 1, 1, ev(0,1,1,1,1,0,0,16'h0BEE), "D_hold2");
    idle_step(ev(0,1,1,1,1,0,0,16'h0BEE), "D_hold3");
    idle_step(ev(0,0,1,0,1,0,0,16'h0BEE), "D_flush");
    idle_step(ev(0,0,0,0,1,0,0,16'h0BEE), "D_idle");

    // flag_stall still driven while frozen in IDLE; flags 1/1/1 then reset mid-FLUSH
    step(1, 0, '0, 1, 1, 1, 1, 1, ev(1,0,0,0,1,0,0,16'h0BEE), "E_stall_frozen");
    step(1, 0, '0, 1, 1, 1, 1, 0, ev(1,0,0,0,1,0,0,16'h0BEE), "E_stall");
    step(1, 1, 16'h0ABC, 0, 0, 0, 0, 0, ev(0,0,0,0,1,1,1,16'h0BEE), "E_reeval");
    idle_step(ev(0,1,1,1,1,1,1,16'h0ABC), "E_redirect");
    rst_n = 1'b0;
    idle_step(ev(0,0,0,0,0,0,0,16'h0000), "E_reset_midflush");
    rst_n = 1'b1;
    step(1, 1, 16'h0040, 0, 0, 0, 0, 0, ev(0,0,0,0,0,0,0,16'h0000), "E_release");
    idle_step(ev(0,1,1,1,0,0,0,16'h0040), "E_redirect2");
    idle_step(ev(0,0,1,0,0,0,0,16'h0040), "E_flush2");
    idle_step(ev(0,0,0,0,0,0,0,16'h0040), "E_idle2");

`ifdef BR_FLOW_STATS_EN
    check16(taken_cnt, 16'd1, "S_taken_after_reset");
    check16(stall_cnt, 16'd0, "S_stall_after_reset");
    step(1, 0, '0, 1, 0, 0, 0, 0, ev(1,0,0,0,0,0,0,16'h0040), "S_interlock");
    step(1, 0, '0, 0, 0, 0, 0, 0, ev(0,0,0,0,0,0,0,16'h0040), "S_nottaken");
    idle_step(ev(0,0,0,0,0,0,0,16'h0040), "S_idle");
    check16(stall_cnt, 16'd1, "S_stall_one");
    id_is_br  = 1'b1;
    br_taken  = 1'b1;
    br_target = 16'h0100;
    repeat (3 * 70000) @(posedge clk);
    #1;
    id_is_br = 1'b0;
    br_taken = 1'b0;
    check16(taken_cnt, 16'hFFFF, "S_taken_saturate");
`endif

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
